// File: rtl/debug_run_controller_if.sv
// Command/status bundle between the debug command decoder, the pipeline/cycle counter
// and debug_run_controller. The controller connects through the slave modport.
interface debug_run_controller_if #(
  parameter int NB_COUNT = 8,
  parameter int NB_PC    = 32
);
  logic                cmd_valid;
  logic [1:0]          cmd;
  logic                halt;
  logic [NB_COUNT-1:0] count_cycles;
  logic [NB_PC-1:0]    pc;
  logic [NB_PC-1:0]    bp_addr;

  logic                en_pipeline;
  logic                en_count;
  logic                clear_count;
  logic [1:0]          state;
  logic                done;
  logic                timeout;
  logic                cmd_err;

  modport master (
    output cmd_valid, cmd, halt, count_cycles, pc, bp_addr,
    input  en_pipeline, en_count, clear_count, state, done, timeout, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd, halt, count_cycles, pc, bp_addr,
    output en_pipeline, en_count, clear_count, state, done, timeout, cmd_err
  );
endinterface

// File: rtl/debug_run_controller.sv
// Run/step/stop/clear sequencer for the MIPS pipeline debug unit.
// Optional PC breakpoint pause is built only when BREAKPOINT_EN is defined.
module debug_run_controller #(
  parameter int NB_COUNT = 8,
  parameter int NB_PC    = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  debug_run_controller_if.slave  bus
);

  // state | meaning
  // IDLE  | pipeline frozen, waiting for RUN/STEP/CLEAR
  // RUN   | pipeline free-running until halt, saturation, breakpoint or STOP
  // STEP  | exactly one enabled pipeline cycle
  // DONE  | run ended (halt or timeout); only CLEAR leaves
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic [1:0]          CMD_RUN   = 2'b00;
  localparam logic [1:0]          CMD_STEP  = 2'b01;
  localparam logic [1:0]          CMD_STOP  = 2'b10;
  localparam logic [1:0]          CMD_CLEAR = 2'b11;
  localparam logic [NB_COUNT-1:0] COUNT_SAT = '1;

  state_t r_state;
  logic   r_en;
  logic   r_clear;
  logic   r_done;
  logic   r_timeout;
  logic   r_err;

  logic   w_sat;
  logic   w_stop;

  assign w_sat  = (bus.count_cycles == COUNT_SAT);
  assign w_stop = bus.cmd_valid && (bus.cmd == CMD_STOP);

`ifdef BREAKPOINT_EN
  logic w_bp_hit;
  assign w_bp_hit = (bus.pc[NB_PC-1:0] == bus.bp_addr[NB_PC-1:0]);
`else
  logic [NB_PC-1:0] w_unused_pc;
  assign w_unused_pc = bus.pc ^ bus.bp_addr;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_en      <= 1'b0;
      r_clear   <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_clear <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            case (bus.cmd)
              CMD_RUN: begin
                r_state <= ST_RUN;
                r_en    <= 1'b1;
              end
              CMD_STEP: begin
                r_state <= ST_STEP;
                r_en    <= 1'b1;
              end
              CMD_CLEAR: begin
                r_clear   <= 1'b1;
                r_timeout <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          // The command is still illegal even when a halt or timeout ends the run this cycle.
          if (bus.cmd_valid && (bus.cmd != CMD_STOP))
            r_err <= 1'b1;
          if (bus.halt) begin
            r_state   <= ST_DONE;
            r_en      <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b0;
          end else if (w_sat) begin
            r_state   <= ST_DONE;
            r_en      <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end
`ifdef BREAKPOINT_EN
          else if (w_bp_hit) begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
          end
`endif
          else if (w_stop) begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
          end
        end
        ST_STEP: begin
          r_en <= 1'b0;
          if (bus.cmd_valid)
            r_err <= 1'b1;
          if (bus.halt) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_timeout <= 1'b0;
          end else if (w_sat) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd == CMD_CLEAR) begin
              r_state   <= ST_IDLE;
              r_done    <= 1'b0;
              r_clear   <= 1'b1;
              r_timeout <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_en    <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.en_pipeline = r_en;
  assign bus.en_count    = r_en;
  assign bus.clear_count = r_clear;
  assign bus.state       = r_state;
  assign bus.done        = r_done;
  assign bus.timeout     = r_timeout;
  assign bus.cmd_err     = r_err;

endmodule

// File: tb/tb_debug_run_controller.sv
// Directed scoreboard bench for debug_run_controller; breakpoint steps follow BREAKPOINT_EN.
module tb_debug_run_controller;
  localparam int NB_COUNT = 8;
  localparam int NB_PC    = 32;

  localparam logic [1:0] I = 2'b00, R = 2'b01, S = 2'b10, D = 2'b11;
  localparam logic [1:0] C_RUN = 2'b00, C_STEP = 2'b01, C_STOP = 2'b10, C_CLR = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_run_controller_if #(.NB_COUNT(NB_COUNT), .NB_PC(NB_PC)) bus ();

  debug_run_controller #(.NB_COUNT(NB_COUNT), .NB_PC(NB_PC)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // {state, en_pipeline, en_count, clear_count, done, timeout, cmd_err}
  function automatic logic [7:0] mk(input logic [1:0] st, input logic clr, input logic err,
                                    input logic to);
    logic en;
    en = (st == R) || (st == S);
    return {st, en, en, clr, (st == D), to, err};
  endfunction

  function automatic logic [7:0] observed();
    return {bus.state, bus.en_pipeline, bus.en_count, bus.clear_count, bus.done,
            bus.timeout, bus.cmd_err};
  endfunction

  task automatic cyc(input string tag, input logic r, input logic v, input logic [1:0] c,
                     input logic h, input logic [7:0] cnt, input logic [1:0] est,
                     input logic eclr, input logic eerr, input logic eto);
    exp_t e;
    logic [7:0] obs;
    rst              = r;
    bus.cmd_valid    = v;
    bus.cmd          = c;
    bus.halt         = h;
    bus.count_cycles = cnt;
    sb.push_back('{tag, mk(est, eclr, eerr, eto)});
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    obs = observed();
    n_cmp++;
    assert (obs === e.exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
    end
  endtask

  initial begin
    bus.cmd_valid    = 1'b0;
    bus.cmd          = 2'b00;
    bus.halt         = 1'b0;
    bus.count_cycles = '0;
    bus.pc           = '0;
    bus.bp_addr      = 32'h10;

    cyc("reset0", 1, 0, 0, 0, 8'h00, I, 0, 0, 0);
    cyc("reset1", 1, 0, 0, 0, 8'h00, I, 0, 0, 0);

    // RUN, halt on the fifth enabled cycle
    cyc("run_cmd", 0, 1, C_RUN, 0, 8'h00, R, 0, 0, 0);
    for (int k = 1; k < 5; k++)
      cyc($sformatf("run_cyc%0d", k), 0, 0, 0, 0, k[7:0], R, 0, 0, 0);
    cyc("run_halt", 0, 0, 0, 1, 8'h05, D, 0, 0, 0);
    cyc("done_frozen", 0, 0, 0, 1, 8'hFF, D, 0, 0, 0);
    cyc("done_run_err", 0, 1, C_RUN, 0, 8'h05, D, 0, 1, 0);
    cyc("done_err_end", 0, 0, 0, 0, 8'h05, D, 0, 0, 0);
    cyc("done_clear", 0, 1, C_CLR, 0, 8'h05, I, 1, 0, 0);
    cyc("clear_end", 0, 0, 0, 0, 8'h00, I, 0, 0, 0);

    // three spaced single steps
    for (int k = 0; k < 3; k++) begin
      cyc($sformatf("step%0d_on", k), 0, 1, C_STEP, 0, 8'h00, S, 0, 0, 0);
      cyc($sformatf("step%0d_off", k), 0, 0, 0, 0, 8'h01, I, 0, 0, 0);
      cyc($sformatf("step%0d_gap", k), 0, 0, 0, 0, 8'h01, I, 0, 0, 0);
    end
    cyc("idle_stop", 0, 1, C_STOP, 0, 8'h01, I, 0, 0, 0);
    cyc("idle_halt", 0, 0, 0, 1, 8'hFF, I, 0, 0, 0);
    cyc("idle_clear", 0, 1, C_CLR, 0, 8'h01, I, 1, 0, 0);

    // timeout by saturation
    cyc("to_run", 0, 1, C_RUN, 0, 8'h00, R, 0, 0, 0);
    cyc("to_7f", 0, 0, 0, 0, 8'h7F, R, 0, 0, 0);
    cyc("to_fe", 0, 0, 0, 0, 8'hFE, R, 0, 0, 0);
    cyc("to_ff", 0, 0, 0, 0, 8'hFF, D, 0, 0, 1);
    cyc("to_hold", 0, 0, 0, 0, 8'hFF, D, 0, 0, 1);
    cyc("to_stop_err", 0, 1, C_STOP, 0, 8'hFF, D, 0, 1, 1);
    cyc("to_clear", 0, 1, C_CLR, 0, 8'hFF, I, 1, 0, 0);
    cyc("to_after", 0, 0, 0, 0, 8'h00, I, 0, 0, 0);

    // illegal commands in RUN, STOP, then STOP+halt
    cyc("r2_run", 0, 1, C_RUN, 0, 8'h00, R, 0, 0, 0);
    cyc("r2_run_err", 0, 1, C_RUN, 0, 8'h01, R, 0, 1, 0);
    cyc("r2_step_err", 0, 1, C_STEP, 0, 8'h02, R, 0, 1, 0);
    cyc("r2_clr_err", 0, 1, C_CLR, 0, 8'h03, R, 0, 1, 0);
    cyc("r2_stop", 0, 1, C_STOP, 0, 8'h04, I, 0, 0, 0);
    cyc("r3_run", 0, 1, C_RUN, 0, 8'h04, R, 0, 0, 0);
    cyc("r3_stop_halt", 0, 1, C_STOP, 1, 8'h05, D, 0, 0, 0);
    cyc("r3_run_err", 0, 1, C_RUN, 0, 8'h05, D, 0, 1, 0);
    cyc("r3_clear", 0, 1, C_CLR, 0, 8'h05, I, 1, 0, 0);

    // halt beats saturation
    cyc("r4_run", 0, 1, C_RUN, 0, 8'h00, R, 0, 0, 0);
    cyc("r4_halt_sat", 0, 0, 0, 1, 8'hFF, D, 0, 0, 0);
    cyc("r4_clear", 0, 1, C_CLR, 0, 8'hFF, I, 1, 0, 0);

    // STEP ending on saturation, on halt, and with a command during STEP
    cyc("s_sat_on", 0, 1, C_STEP, 0, 8'hFE, S, 0, 0, 0);
    cyc("s_sat", 0, 0, 0, 0, 8'hFF, D, 0, 0, 1);
    cyc("s_sat_clr", 0, 1, C_CLR, 0, 8'hFF, I, 1, 0, 0);
    cyc("s_halt_on", 0, 1, C_STEP, 0, 8'h00, S, 0, 0, 0);
    cyc("s_halt", 0, 0, 0, 1, 8'h01, D, 0, 0, 0);
    cyc("s_halt_clr", 0, 1, C_CLR, 0, 8'h01, I, 1, 0, 0);
    cyc("s_cmd_on", 0, 1, C_STEP, 0, 8'h00, S, 0, 0, 0);
    cyc("s_cmd_err", 0, 1, C_STOP, 0, 8'h01, I, 0, 1, 0);

    // reset in the middle of a run
    cyc("rr_run", 0, 1, C_RUN, 0, 8'h01, R, 0, 0, 0);
    cyc("rr_reset", 1, 1, C_CLR, 0, 8'h02, I, 0, 0, 0);
    cyc("rr_after", 0, 0, 0, 0, 8'h00, I, 0, 0, 0);

`ifdef BREAKPOINT_EN
    bus.pc = 32'h0;
    cyc("bp_run", 0, 1, C_RUN, 0, 8'h00, R, 0, 0, 0);
    for (int k = 1; k < 4; k++) begin
      bus.pc = 32'(k * 4);
      cyc($sformatf("bp_pc%0d", k * 4), 0, 0, 0, 0, k[7:0], R, 0, 0, 0);
    end
    bus.pc = 32'h10;
    cyc("bp_hit", 0, 0, 0, 0, 8'h04, I, 0, 0, 0);
    cyc("bp_step_on", 0, 1, C_STEP, 0, 8'h04, S, 0, 0, 0);
    cyc("bp_step_past", 0, 0, 0, 0, 8'h05, I, 0, 0, 0);
    bus.pc = 32'h14;
    cyc("bp_rerun", 0, 1, C_RUN, 0, 8'h05, R, 0, 0, 0);
    bus.pc = 32'h18;
    cyc("bp_beyond", 0, 0, 0, 0, 8'h06, R, 0, 0, 0);
    cyc("bp_stop", 0, 1, C_STOP, 0, 8'h07, I, 0, 0, 0);
    bus.pc = 32'h10;
    cyc("bp_sat_run", 0, 1, C_RUN, 0, 8'h07, R, 0, 0, 0);
    cyc("bp_sat_wins", 0, 0, 0, 0, 8'hFF, D, 0, 0, 1);
    cyc("bp_sat_clr", 0, 1, C_CLR, 0, 8'hFF, I, 1, 0, 0);
`else
    bus.pc = 32'h10;
    cyc("nobp_run", 0, 1, C_RUN, 0, 8'h00, R, 0, 0, 0);
    cyc("nobp_pc_match", 0, 0, 0, 0, 8'h01, R, 0, 0, 0);
    cyc("nobp_stop", 0, 1, C_STOP, 0, 8'h02, I, 0, 0, 0);
`endif

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
